// File: rtl/difftest_int_delayed_update_sched.sv
// Delayed integer writeback scheduler: round-robin collects requester events,
// drops x0 writes, buffers the rest and emits one numbered event per cycle.
module difftest_int_delayed_update_sched #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [5*NUM_REQ-1:0]          req_address,
  input  logic [64*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]            req_nack,
  input  logic [7:0]                    io_coreid,
  input  logic                          sink_stall,
  output logic                          out_enable,
  output logic [4:0]                    out_address,
  output logic [63:0]                   out_data,
  output logic                          out_nack,
  output logic [7:0]                    out_coreid,
  output logic [7:0]                    out_index,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [15:0]                   x0_drop_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef struct packed {
    logic [4:0]  address;
    logic [63:0] data;
    logic        nack;
  } event_t;

  event_t             mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   last_grant;
  logic [7:0]         index_cnt;

  logic               not_full;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  event_t             grant_ev;
  logic               grant_x0;
  logic               push;
  logic               pop;

  // x0 events never occupy a slot, so they stay eligible while full
  always_comb begin
    not_full = count < CNT_W'(FIFO_DEPTH);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = req_valid[i] && (not_full || req_address[5*i +: 5] == 5'd0);
    end
  end

  // Search upward from the requester after the last grant, wrapping
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(last_grant) + 32'd1 + k) % NUM_REQ;
      if (!grant_found && eligible[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    grant_ev.address = req_address[5*int'(grant_idx) +: 5];
    grant_ev.data    = req_data[64*int'(grant_idx) +: 64];
    grant_ev.nack    = req_nack[grant_idx];
    grant_x0         = grant_ev.address == 5'd0;
    push             = grant_found && !grant_x0;
    pop              = (count != '0) && !sink_stall;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = grant_found && (grant_idx == PTR_W'(i));
    end
  end

  assign occupancy = count;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= grant_ev;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_grant  <= PTR_W'(NUM_REQ - 1);
      index_cnt   <= '0;
      x0_drop_cnt <= '0;
      out_enable  <= 1'b0;
      out_address <= '0;
      out_data    <= '0;
      out_nack    <= 1'b0;
      out_coreid  <= '0;
      out_index   <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (grant_found) begin
        last_grant <= grant_idx;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (grant_found && grant_x0 && x0_drop_cnt != 16'hFFFF) begin
        x0_drop_cnt <= x0_drop_cnt + 16'd1;
      end
      out_enable <= pop;
      // Payload fields hold their last values when nothing is emitted
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        out_address <= mem[rd_ptr].address;
        out_data    <= mem[rd_ptr].data;
        out_nack    <= mem[rd_ptr].nack;
        out_coreid  <= io_coreid;
        out_index   <= index_cnt;
        index_cnt   <= index_cnt + 8'd1;
      end
    end
  end

endmodule
